pwm_sample_fifo: RTL

- Buffered audio sample source for the PWM DAC.
- Absorbs bursts of 8-bit samples written by the Gigatron through the ctrl-code device strobe.
- Releases them one at a time into the PWM threshold register, at a programmable sample rate derived from CLK.
- Sits directly upstream of the bit-reversed PWM comparator: its PWMD output replaces the directly-written threshold, so audio no longer depends on exact instruction timing.

---
 rtl/pwm_sample_fifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/pwm_sample_fifo.sv
// Sample FIFO feeding the PWM threshold register: absorbs bursts of 8-bit
// samples and releases one per programmable sample period.
module pwm_sample_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  IDLE       = 8'h00
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  WR,
  input  logic [7:0]            WDATA,
  input  logic                  FLUSH,
  input  logic                  RATE_WR,
  input  logic [7:0]            RATE,
  input  logic                  ENABLE,
  input  logic                  CLRSTAT,
  output logic [7:0]            PWMD,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  UNDERRUN,
  output logic                  OVERRUN
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [7:0]            rate_q;
  logic [7:0]            cnt;

  logic                  tick;
  logic                  pop;
  logic                  push;
  logic                  ur_set;
  logic                  ov_set;
  logic [DEPTH_LOG2:0]   level_nxt;

  // Push protocol: WR is a one-cycle strobe with no back-pressure; a push that
  // meets a full FIFO (and no same-edge pop) is dropped and flagged in OVERRUN.
  always_comb begin
    tick      = ENABLE && !RATE_WR && (cnt == 8'd0);
    pop       = tick && !FLUSH && (LEVEL != '0);
    push      = WR && !FLUSH && ((LEVEL != FULL_LVL) || pop);
    ur_set    = tick && !FLUSH && (LEVEL == '0);
    ov_set    = WR && !FLUSH && (LEVEL == FULL_LVL) && !pop;
    level_nxt = LEVEL;
    if (FLUSH)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = LEVEL + 1'b1;
    else if (pop && !push)
      level_nxt = LEVEL - 1'b1;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rate_q <= 8'hFF;
      cnt    <= 8'hFF;
    end else if (RATE_WR) begin
      rate_q <= RATE;
      cnt    <= RATE;
    end else if (!ENABLE || cnt == 8'd0) begin
      cnt    <= rate_q;
    end else begin
      cnt    <= cnt - 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      PWMD     <= IDLE;
      LEVEL    <= '0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      UNDERRUN <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      LEVEL    <= level_nxt;
      EMPTY    <= (level_nxt == '0);
      FULL     <= (level_nxt == FULL_LVL);
      UNDERRUN <= ur_set | (UNDERRUN & ~CLRSTAT);
      OVERRUN  <= ov_set | (OVERRUN & ~CLRSTAT);
      if (FLUSH) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        PWMD   <= IDLE;
      end else begin
        if (pop) begin
          PWMD   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= WDATA;
  end

endmodule
